clk_div_prog: RTL and testbench

//  Runtime-programmable clock divider. Generalises the fixed /2,/4,/8 divider to any ratio 2..2^DIV_WD+1.

---
 rtl/clk_div_prog.sv | 108 ++++++++++
 tb/tb_clk_div_prog.sv | 139 +++++++++++++
 2 files changed

// File: rtl/clk_div_prog.sv
// Runtime-programmable clock divider (R = cfg_div+2); optional CLK_DIV_ODD50_EN gives odd ratios 50% duty.
// Latency: outputs registered from next-state, so an enable seen at an edge drives clk_out/clk_tick from that edge.
// No backpressure: free-running once enabled; ratio/enable changes only act on period boundaries.
module clk_div_prog #(
   parameter int DIV_WD = 8
) (
   input  logic              mclk,
   input  logic              reset,
   input  logic              cfg_en,
   input  logic [DIV_WD-1:0] cfg_div,
   output logic              clk_out,
   output logic              clk_tick,
   output logic              div_run,
   output logic [DIV_WD-1:0] cur_div
);

   localparam int CW = DIV_WD + 1;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t        state;
   state_t        next_state;
   logic [CW-1:0] cnt;
   logic [CW-1:0] next_cnt;
   logic [CW-1:0] ratio_q;
   logic [CW-1:0] next_ratio;
   logic [CW-1:0] cfg_ratio;
   logic [CW-1:0] term_cnt;
   logic [CW-1:0] next_h;
   logic          clk_out_q;

   // Extra bit keeps cfg_div all-ones + 2 from wrapping.
   assign cfg_ratio = {1'b0, cfg_div} + CW'(2);
   assign term_cnt  = ratio_q - CW'(1);
   assign next_h    = next_ratio >> 1;

   always_comb begin
      next_state = state;
      next_cnt   = cnt;
      next_ratio = ratio_q;
      case (state)
         IDLE: begin
            next_cnt = '0;
            if (cfg_en) begin
               next_state = RUN;
               next_ratio = cfg_ratio;
            end
         end
         RUN: begin
            if (cnt == term_cnt) begin
               next_cnt = '0;
               if (cfg_en) begin
                  next_ratio = cfg_ratio;
               end else begin
                  next_state = IDLE;
               end
            end else begin
               next_cnt = cnt + CW'(1);
            end
         end
         default: begin
            next_state = IDLE;
            next_cnt   = '0;
         end
      endcase
   end

   always_ff @(posedge mclk) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= '0;
         ratio_q   <= CW'(2);
         clk_out_q <= 1'b0;
         clk_tick  <= 1'b0;
         div_run   <= 1'b0;
      end else begin
         state     <= next_state;
         cnt       <= next_cnt;
         ratio_q   <= next_ratio;
         clk_out_q <= (next_state == RUN) && (next_cnt < next_h);
         clk_tick  <= (next_state == RUN) && (next_cnt == '0);
         div_run   <= (next_state == RUN);
      end
   end

   assign cur_div = ratio_q[DIV_WD-1:0] - DIV_WD'(2);

`ifdef CLK_DIV_ODD50_EN
   logic clk_neg;

   // Half-cycle extension of the high phase; masked for even ratios.
   always_ff @(negedge mclk) begin
      if (reset) begin
         clk_neg <= 1'b0;
      end else begin
         clk_neg <= clk_out_q;
      end
   end

   assign clk_out = clk_out_q | (ratio_q[0] & clk_neg);
`else
   assign clk_out = clk_out_q;
`endif

endmodule

// File: tb/tb_clk_div_prog.sv
// Scoreboard bench for clk_div_prog: stimulus pushes the expected post-edge outputs, a monitor pops one per cycle.
module tb_clk_div_prog;

   logic       mclk;
   logic       reset;
   logic       cfg_en;
   logic [7:0] cfg_div;
   logic       clk_out;
   logic       clk_tick;
   logic       div_run;
   logic [7:0] cur_div;

   typedef struct packed {
      logic       o;
      logic       t;
      logic       r;
      logic [7:0] c;
   } exp_t;

   exp_t sb[$];
   int   n_cmp  = 0;
   int   n_bad  = 0;
   int   cyc    = 0;
   logic prev_q = 1'b0;

   clk_div_prog #(.DIV_WD(8)) dut (
      .mclk     (mclk),
      .reset    (reset),
      .cfg_en   (cfg_en),
      .cfg_div  (cfg_div),
      .clk_out  (clk_out),
      .clk_tick (clk_tick),
      .div_run  (div_run),
      .cur_div  (cur_div)
   );

   initial begin
      mclk = 1'b0;
      forever #5 mclk = ~mclk;
   end

   // Drive inputs for the next edge and queue the outputs expected right after it.
   task automatic step(input logic rst, input logic en, input logic [7:0] div,
                       input logic eo, input logic et, input logic er, input logic [7:0] ec);
      exp_t e;
      @(posedge mclk);
      #2;
      reset   = rst;
      cfg_en  = en;
      cfg_div = div;
`ifdef CLK_DIV_ODD50_EN
      e.o = eo | (ec[0] & prev_q);
`else
      e.o = eo;
`endif
      prev_q = eo;
      e.t = et;
      e.r = er;
      e.c = ec;
      sb.push_back(e);
   endtask

   // One full period of ratio r: loads d_load at its first edge, then holds d_rest/en_rest.
   task automatic period(input int r, input logic [7:0] d_load, input logic [7:0] d_rest,
                         input logic en_rest);
      step(1'b0, 1'b1, d_load, 1'b1, 1'b1, 1'b1, d_load);
      for (int c = 1; c < r; c++) begin
         step(1'b0, en_rest, d_rest, (c < r / 2), 1'b0, 1'b1, d_load);
      end
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge mclk);
         #1;
         cyc++;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            n_cmp++;
            if (clk_out !== e.o || clk_tick !== e.t || div_run !== e.r || cur_div !== e.c) begin
               n_bad++;
               $display("FAIL outputs cyc%0d: got out=%b tick=%b run=%b cur=%0d, want out=%b tick=%b run=%b cur=%0d",
                        cyc, clk_out, clk_tick, div_run, cur_div, e.o, e.t, e.r, e.c);
            end
         end
      end
   end

   initial begin : stim
      reset   = 1'b1;
      cfg_en  = 1'b0;
      cfg_div = 8'd0;

      // Reset state
      step(1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 8'd0);
      step(1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 8'd0);
      step(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 8'd0);

      // R=2: toggles every cycle, tick on first cycle after enable
      for (int i = 0; i < 4; i++) period(2, 8'd0, 8'd0, 1'b1);

      // R=5: high 2, low 3
      for (int i = 0; i < 3; i++) period(5, 8'd3, 8'd3, 1'b1);

      // Ratio change mid-period: current period stays 5, then 8
      period(5, 8'd3, 8'd6, 1'b1);
      for (int i = 0; i < 2; i++) period(8, 8'd6, 8'd6, 1'b1);

      // Stop at cnt==1 with R=5: period completes, then idle
      period(5, 8'd3, 8'd3, 1'b0);
      for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 8'd3, 1'b0, 1'b0, 1'b0, 8'd3);
      period(5, 8'd3, 8'd3, 1'b1);

      // Max ratio 257: high 128, low 129, then stop
      period(257, 8'hFF, 8'hFF, 1'b1);
      period(257, 8'hFF, 8'hFF, 1'b0);
      step(1'b0, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 8'hFF);

      // Reset during high phase, then clean restart
      step(1'b0, 1'b1, 8'd6, 1'b1, 1'b1, 1'b1, 8'd6);
      step(1'b0, 1'b1, 8'd6, 1'b1, 1'b0, 1'b1, 8'd6);
      step(1'b1, 1'b1, 8'd6, 1'b0, 1'b0, 1'b0, 8'd0);
      for (int i = 0; i < 2; i++) period(8, 8'd6, 8'd6, 1'b1);
      step(1'b0, 1'b0, 8'd6, 1'b0, 1'b0, 1'b0, 8'd6);
      step(1'b0, 1'b0, 8'd6, 1'b0, 1'b0, 1'b0, 8'd6);

      for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge mclk);
      #3;
      n_cmp++;
      if (sb.size() != 0) begin
         n_bad++;
         $display("FAIL drain: got %0d pending entries, want 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
